// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit write engine.
// Default timings assume a 50 MHz clk.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SETUP_H   = 4'd1,
    ST_PULSE_H   = 4'd2,
    ST_HOLD_H    = 4'd3,
    ST_GAP       = 4'd4,
    ST_SETUP_L   = 4'd5,
    ST_PULSE_L   = 4'd6,
    ST_HOLD_L    = 4'd7,
    ST_WAIT_EXEC = 4'd8,
    ST_DONE      = 4'd9
  } lcd_state_e;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 12;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_GAP_DEF   = 50;
  localparam int T_EXEC_DEF  = 2000;
  localparam int T_LONG_DEF  = 82000;
  localparam int CNT_W_DEF   = 17;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;

  // Clear (0x01) and home (0x02/0x03) are the only slow instructions.
  function automatic logic is_long_cmd(input logic [5:0] data_hi6,
                                       input logic       rs,
                                       input logic       nibble);
    return !rs && !nibble && (data_hi6 == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter; expired marks the last cycle of a timed interval.
module lcd_delay_cnt #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lcd_write_ctrl.sv
// HD44780 4-bit write engine: sends a byte (or a lone high nibble), then waits
// out the controller execution time before pulsing wr_finish.
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int T_EXEC  = T_EXEC_DEF,
  parameter int T_LONG  = T_LONG_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_enable,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  input  logic       wr_nibble,
  output logic       wr_finish,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_db
);

  // state      | meaning
  // IDLE       | waiting for wr_enable; bus holds last value
  // SETUP_H    | high nibble on DB, E low
  // PULSE_H    | E high, high nibble
  // HOLD_H     | E low, high nibble still held
  // GAP        | inter-nibble spacing
  // SETUP_L    | low nibble on DB, E low
  // PULSE_L    | E high, low nibble
  // HOLD_L     | E low, low nibble still held
  // WAIT_EXEC  | LCD executing the command
  // DONE       | wr_finish pulse

  if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || T_GAP < 1 ||
      T_EXEC < 1 || T_LONG < 1) begin : g_bad_timing
    $error("lcd_write_ctrl: timing parameters must be at least 1");
  end
  if ((64'(1) << CNT_W) <= 64'(T_LONG)) begin : g_bad_cnt_w
    $error("lcd_write_ctrl: CNT_W too narrow for T_LONG");
  end

  lcd_state_e       state_q, state_d;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             nib_q;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_expired;
  logic [CNT_W-1:0] wait_len;

  assign accept   = (state_q == ST_IDLE) && wr_enable;
  assign wait_len = is_long_cmd(data_q[7:2], rs_q, nib_q) ? CNT_W'(T_LONG)
                                                          : CNT_W'(T_EXEC);

  lcd_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .value   (cnt_value),
    .expired (cnt_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (wr_enable) begin
          state_d   = ST_SETUP_H;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_SETUP);
        end
      end
      ST_SETUP_H: begin
        if (cnt_expired) begin
          state_d   = ST_PULSE_H;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_PULSE);
        end
      end
      ST_PULSE_H: begin
        if (cnt_expired) begin
          state_d   = ST_HOLD_H;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_HOLD);
        end
      end
      ST_HOLD_H: begin
        if (cnt_expired) begin
          cnt_load = 1'b1;
          if (nib_q) begin
            state_d   = ST_WAIT_EXEC;
            cnt_value = wait_len;
          end else begin
            state_d   = ST_GAP;
            cnt_value = CNT_W'(T_GAP);
          end
        end
      end
      ST_GAP: begin
        if (cnt_expired) begin
          state_d   = ST_SETUP_L;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_SETUP);
        end
      end
      ST_SETUP_L: begin
        if (cnt_expired) begin
          state_d   = ST_PULSE_L;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_PULSE);
        end
      end
      ST_PULSE_L: begin
        if (cnt_expired) begin
          state_d   = ST_HOLD_L;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(T_HOLD);
        end
      end
      ST_HOLD_L: begin
        if (cnt_expired) begin
          state_d   = ST_WAIT_EXEC;
          cnt_load  = 1'b1;
          cnt_value = wait_len;
        end
      end
      ST_WAIT_EXEC: begin
        if (cnt_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      nib_q  <= 1'b0;
    end else if (accept) begin
      data_q <= wr_data;
      rs_q   <= wr_rs;
      nib_q  <= wr_nibble;
    end
  end

  // Outputs are decoded from the next state and registered, so E is glitch-free
  // and each output lines up exactly with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_finish <= 1'b0;
      busy      <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_db    <= 4'h0;
    end else begin
      wr_finish <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
      lcd_e     <= (state_d == ST_PULSE_H) || (state_d == ST_PULSE_L);
      lcd_rw    <= 1'b0;
      if (accept) begin
        lcd_db <= wr_data[7:4];
        lcd_rs <= wr_rs;
      end else if ((state_q == ST_GAP) && (state_d == ST_SETUP_L)) begin
        lcd_db <= data_q[3:0];
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Self-checking bench for lcd_write_ctrl: directed cases plus random writes
// against a timeline model of the 4-bit write protocol.
module tb_lcd_write_ctrl;

  // Long wait shortened so the clear-command case stays brief; the rest are defaults.
  localparam int TS = 2;
  localparam int TP = 12;
  localparam int TH = 1;
  localparam int TG = 50;
  localparam int TE = 2000;
  localparam int TL = 8200;

  logic       clk;
  logic       rst;
  logic       wr_enable;
  logic [7:0] wr_data;
  logic       wr_rs;
  logic       wr_nibble;
  logic       wr_finish;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_db;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int         fin_q[$];
  int         pw_q[$];
  int         prise_q[$];
  logic [3:0] pdb_q[$];
  logic       prs_q[$];

  logic       prev_e;
  logic [4:0] prev_bus;
  int         last_chg;
  int         last_fall;
  int         rise_cyc;
  logic       rw_high_seen = 1'b0;

  lcd_write_ctrl #(
    .T_LONG (TL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .wr_rs     (wr_rs),
    .wr_nibble (wr_nibble),
    .wr_finish (wr_finish),
    .busy      (busy),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_db    (lcd_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_wait(input logic [7:0] d, input logic r, input logic n);
    return (!r && !n && d < 8'h04) ? TL : TE;
  endfunction

  function automatic int model_latency(input logic [7:0] d, input logic r, input logic n);
    int nibbles;
    nibbles = n ? 1 : 2;
    return 1 + nibbles * (TS + TP + TH) + (nibbles - 1) * TG + model_wait(d, r, n);
  endfunction

  // Bus monitor: records E pulses and finish strobes, checks setup/hold stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_e    = 1'b0;
      prev_bus  = {lcd_rs, lcd_db};
      last_chg  = cyc;
      last_fall = -1000;
    end else begin
      if (lcd_rw) rw_high_seen = 1'b1;
      if (wr_finish) fin_q.push_back(cyc);
      if (prev_e && !lcd_e) begin
        last_fall = cyc;
        pw_q.push_back(cyc - rise_cyc);
      end
      if ({lcd_rs, lcd_db} != prev_bus) begin
        chk_val("bus_change_in_e_or_hold", int'(lcd_e || (cyc < last_fall + TH)), 0);
        last_chg = cyc;
      end
      if (lcd_e && !prev_e) begin
        rise_cyc = cyc;
        chk_val("setup_before_e", int'((cyc - last_chg) >= TS), 1);
        prise_q.push_back(cyc);
        pdb_q.push_back(lcd_db);
        prs_q.push_back(lcd_rs);
      end
      prev_e   = lcd_e;
      prev_bus = {lcd_rs, lcd_db};
    end
  end

  task automatic clear_q();
    fin_q.delete();
    pw_q.delete();
    prise_q.delete();
    pdb_q.delete();
    prs_q.delete();
  endtask

  task automatic strobe(input logic [7:0] d, input logic r, input logic n, output int s);
    wr_data   = d;
    wr_rs     = r;
    wr_nibble = n;
    wr_enable = 1'b1;
    s         = cyc;
    @(negedge clk); #1;
    wr_enable = 1'b0;
  endtask

  task automatic wait_fin(input int bound, output bit ok);
    int k;
    k = 0;
    while (fin_q.size() == 0 && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (fin_q.size() != 0);
    if (!ok) chk_val("wr_finish_timeout", 0, 1);
  endtask

  task automatic verify(input logic [7:0] d, input logic r, input logic n, input int s);
    int np;
    logic [3:0] exp_db;
    np = n ? 1 : 2;
    chk_val("finish_cycle", fin_q[0] - s, model_latency(d, r, n));
    chk_val("finish_count", fin_q.size(), 1);
    chk_val("e_pulse_count", pw_q.size(), np);
    for (int i = 0; i < np && i < pw_q.size(); i++) begin
      exp_db = (i == 0) ? d[7:4] : d[3:0];
      chk_val("e_width", pw_q[i], TP);
      chk_val("pulse_db", int'(pdb_q[i]), int'(exp_db));
      chk_val("pulse_rs", int'(prs_q[i]), int'(r));
    end
    if (prise_q.size() > 0) chk_val("first_rise", prise_q[0] - s, 1 + TS);
    if (np == 2 && prise_q.size() > 1)
      chk_val("second_rise", prise_q[1] - prise_q[0], TP + TH + TG + TS);
    chk_val("busy_at_finish", int'(busy), 1);
    clear_q();
  endtask

  task automatic write_chk(input logic [7:0] d, input logic r, input logic n);
    int s;
    bit ok;
    strobe(d, r, n, s);
    chk_val("busy_after_strobe", int'(busy), 1);
    wait_fin(model_latency(d, r, n) + 20, ok);
    if (ok) verify(d, r, n, s);
    clear_q();
    @(negedge clk); #1;
    chk_val("busy_after_finish", int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_e"},      int'(lcd_e), 0);
    chk_val({tag, "_rs"},     int'(lcd_rs), 0);
    chk_val({tag, "_rw"},     int'(lcd_rw), 0);
    chk_val({tag, "_db"},     int'(lcd_db), 0);
    chk_val({tag, "_busy"},   int'(busy), 0);
    chk_val({tag, "_finish"}, int'(wr_finish), 0);
  endtask

  initial begin
    int  s, s2, s_ign, k;
    bit  ok;
    logic [7:0] rd;
    logic       rr, rn;

    rst       = 1'b1;
    wr_enable = 1'b0;
    wr_data   = 8'h00;
    wr_rs     = 1'b0;
    wr_nibble = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk_all_zero("por");
    rst = 1'b0;
    @(negedge clk); #1;

    // Reset in the middle of the first E pulse.
    strobe(8'h41, 1'b1, 1'b0, s);
    k = 0;
    while (!lcd_e && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk_val("e_seen_before_reset", int'(lcd_e), 1);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_pulse_rst");
    repeat (2) @(negedge clk); #1;
    rst = 1'b0;
    clear_q();
    @(negedge clk); #1;
    chk_val("busy_after_rst", int'(busy), 0);
    chk_val("state_after_rst", int'(dut.state_q), int'(lcd_pkg::ST_IDLE));

    write_chk(8'h41, 1'b1, 1'b0);
    write_chk(8'h01, 1'b0, 1'b0);
    write_chk(8'h28, 1'b0, 1'b0);
    write_chk(8'h30, 1'b0, 1'b1);

    // Strobes while busy and on the finish cycle are dropped; the next IDLE one is taken.
    strobe(8'h48, 1'b1, 1'b0, s);
    repeat (20) @(negedge clk); #1;
    chk_val("busy_mid_write", int'(busy), 1);
    strobe(8'hE7, 1'b0, 1'b0, s_ign);
    wait_fin(model_latency(8'h48, 1'b1, 1'b0) + 20, ok);
    if (ok) begin
      wr_data   = 8'h5A;
      wr_rs     = 1'b0;
      wr_nibble = 1'b1;
      wr_enable = 1'b1;
      verify(8'h48, 1'b1, 1'b0, s);
      @(negedge clk); #1;
      chk_val("busy_idle_after_done", int'(busy), 0);
      wr_data   = 8'hC3;
      wr_rs     = 1'b1;
      wr_nibble = 1'b0;
      s2        = cyc;
      @(negedge clk); #1;
      wr_enable = 1'b0;
      chk_val("busy_restart", int'(busy), 1);
      wait_fin(model_latency(8'hC3, 1'b1, 1'b0) + 20, ok);
      if (ok) verify(8'hC3, 1'b1, 1'b0, s2);
      clear_q();
      @(negedge clk); #1;
      chk_val("busy_after_restart", int'(busy), 0);
    end
    wr_enable = 1'b0;
    clear_q();

    for (int i = 0; i < 10; i++) begin
      rd = 8'($urandom);
      rr = 1'($urandom);
      rn = ($urandom_range(3) == 0);
      repeat ($urandom_range(3)) @(negedge clk);
      #1;
      write_chk(rd, rr, rn);
    end

    chk_val("rw_never_high", int'(rw_high_seen), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
